// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef logic owner_t;

    localparam owner_t     OWN_I   = 1'b0;
    localparam owner_t     OWN_D   = 1'b1;
    localparam logic [3:0] BE_WORD = 4'hF;

    // Saturating increment of the data-grant streak counter.
    function automatic logic [3:0] streak_sat_inc(input logic [3:0] cur, input logic [3:0] max_v);
        logic [3:0] nxt;
        if (cur >= max_v) begin
            nxt = max_v;
        end else begin
            nxt = cur + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the memory.
// The arbiter takes the slave view; the core/memory environment takes master.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;

    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_be;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          stall;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. One access at a time: grant in IDLE, wait for the memory in
// BUSY, pulse the owner's ack in RESP. Data normally wins, but a waiting
// fetch is guaranteed a slot after STREAK_MAX consecutive data grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic           CLK,
    input  logic           RST,
    mem_arbiter_if.slave   bus
);

    localparam logic [3:0] STREAK_CAP = 4'(STREAK_MAX);

    arb_state_t    state_r;
    owner_t        owner_r;
    logic [3:0]    streak_r;
    logic          mem_req_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic [3:0]    mem_be_r;
    logic          i_ack_r;
    logic          d_ack_r;
    logic [DW-1:0] i_rdata_r;
    logic [DW-1:0] d_rdata_r;

    logic          d_req_s;
    logic          d_win_s;
    logic          i_win_s;

    // Grant decision: data wins unless a fetch has waited through a full streak.
    always_comb begin
        d_req_s = bus.d_read | bus.d_write;
        d_win_s = 1'b0;
        i_win_s = 1'b0;
        if (d_req_s && !(bus.i_req && (streak_r == STREAK_CAP))) begin
            d_win_s = 1'b1;
        end else if (bus.i_req) begin
            i_win_s = 1'b1;
        end else begin
            d_win_s = 1'b0;
            i_win_s = 1'b0;
        end
    end

    // Arbitration FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            owner_r     <= OWN_I;
            streak_r    <= 4'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            mem_be_r    <= 4'h0;
            i_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            i_rdata_r   <= {DW{1'b0}};
            d_rdata_r   <= {DW{1'b0}};
        end else begin
            // Acks are single-cycle pulses; they are only set on the BUSY->RESP edge.
            i_ack_r <= 1'b0;
            d_ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (d_win_s) begin
                        owner_r     <= OWN_D;
                        mem_req_r   <= 1'b1;
                        mem_addr_r  <= bus.d_addr;
                        mem_wdata_r <= bus.d_wdata;
                        // A simultaneous read+write is treated as a write.
                        mem_we_r    <= bus.d_write;
                        mem_be_r    <= bus.d_write ? bus.d_be : BE_WORD;
                        streak_r    <= bus.i_req ? streak_sat_inc(streak_r, STREAK_CAP) : 4'd0;
                        state_r     <= BUSY;
                    end else if (i_win_s) begin
                        owner_r     <= OWN_I;
                        mem_req_r   <= 1'b1;
                        mem_addr_r  <= bus.i_addr;
                        mem_wdata_r <= {DW{1'b0}};
                        mem_we_r    <= 1'b0;
                        mem_be_r    <= BE_WORD;
                        streak_r    <= 4'd0;
                        state_r     <= BUSY;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                BUSY: begin
                    // Memory outputs are frozen until the memory completes.
                    if (bus.mem_ack) begin
                        mem_req_r <= 1'b0;
                        if (owner_r == OWN_I) begin
                            i_rdata_r <= bus.mem_rdata;
                            i_ack_r   <= 1'b1;
                        end else begin
                            // Stores leave the load-data register untouched.
                            if (!mem_we_r) begin
                                d_rdata_r <= bus.mem_rdata;
                            end else begin
                                d_rdata_r <= d_rdata_r;
                            end
                            d_ack_r   <= 1'b1;
                        end
                        state_r   <= RESP;
                    end else begin
                        state_r   <= BUSY;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i_ack     = i_ack_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_be    = mem_be_r;

    // Stall drops in the ack cycle so the core advances on that edge.
    assign bus.stall = (bus.i_req & ~i_ack_r) | (d_req_s & ~d_ack_r);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a vector table of single accesses,
// hand-written contention / spurious-ack / mid-access reset sequences, and a
// scoreboard of expected acks popped when the arbiter acknowledges.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .STREAK_MAX(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic        is_d;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          busy;
        logic [31:0] mrdata;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic        chk_wdata;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
    } sb_t;

    localparam int NV = 6;

    vec_t        vecs [NV];
    sb_t         sb_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_i_rdata;
    logic [31:0] model_d_rdata;
    logic [31:0] exp_rd;
    logic [9:0]  order;
    logic [31:0] cur_i_addr;
    bit          ok;
    vec_t        t;
    sb_t         e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_grant(output bit got);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (bus.mem_req === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: mem_req got 0, expected 1 within 20 cycles");
        end
    endtask

    // Compare the ack cycle against the oldest scoreboard entry.
    task automatic sb_check();
        sb_t ex;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: ack seen with no expected entry");
        end else begin
            ex = sb_q.pop_front();
            check("ack_i", 32'(bus.i_ack), 32'(ex.owner == OWN_I));
            check("ack_d", 32'(bus.d_ack), 32'(ex.owner == OWN_D));
            check("rdata", (ex.owner == OWN_I) ? bus.i_rdata : bus.d_rdata, ex.rdata);
        end
    endtask

    // Hold the memory busy for 'busy' cycles, complete it, then check the ack.
    task automatic finish_access(input int busy, input logic [31:0] mrdata, input logic [31:0] addr_exp);
        for (int k = 1; k < busy; k++) begin
            @(negedge CLK);
            check("busy_hold_req", 32'(bus.mem_req), 32'd1);
            check("busy_hold_addr", bus.mem_addr, addr_exp);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mrdata;
        @(negedge CLK);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        check("req_drop", 32'(bus.mem_req), 32'd0);
        sb_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            is_d  rd    wr    addr           wdata          be     busy mrdata         we    be     chkw  exp_wdata
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 1, 32'h2008_0005, 1'b0, 4'hF, 1'b1, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 4'h0, 2, 32'h1234_5678, 1'b0, 4'hF, 1'b0, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 3, 32'hFFFF_0000, 1'b1, 4'h3, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 4'hC, 1, 32'h5555_AAAA, 1'b1, 4'hC, 1'b1, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0, 4, 32'hA5A5_5A5A, 1'b0, 4'hF, 1'b1, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, 4'h0, 1, 32'h0BAD_F00D, 1'b0, 4'hF, 1'b0, 32'h0000_0000};

        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_be = 4'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        model_i_rdata = 32'h0;
        model_d_rdata = 32'h0;

        // Reset state.
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_mem_req",   32'(bus.mem_req), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we), 32'd0);
        check("rst_mem_addr",  bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_mem_be",    32'(bus.mem_be), 32'd0);
        check("rst_i_ack",     32'(bus.i_ack), 32'd0);
        check("rst_d_ack",     32'(bus.d_ack), 32'd0);
        check("rst_i_rdata",   bus.i_rdata, 32'h0);
        check("rst_d_rdata",   bus.d_rdata, 32'h0);
        check("rst_stall",     32'(bus.stall), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Table of single accesses.
        for (int v = 0; v < NV; v++) begin
            t = vecs[v];
            bus.i_req   = ~t.is_d;
            bus.i_addr  = t.addr;
            bus.d_read  = t.rd;
            bus.d_write = t.wr;
            bus.d_addr  = t.addr;
            bus.d_wdata = t.wdata;
            bus.d_be    = t.be;
            exp_rd = (t.is_d && t.wr) ? model_d_rdata : t.mrdata;
            sb_q.push_back('{t.is_d ? OWN_D : OWN_I, exp_rd});
            wait_grant(ok);
            if (ok) begin
                check("vec_mem_we",   32'(bus.mem_we), 32'(t.exp_we));
                check("vec_mem_be",   32'(bus.mem_be), 32'(t.exp_be));
                check("vec_mem_addr", bus.mem_addr, t.addr);
                if (t.chk_wdata) begin
                    check("vec_mem_wdata", bus.mem_wdata, t.exp_wdata);
                end
                check("vec_stall_busy", 32'(bus.stall), 32'd1);
                finish_access(t.busy, t.mrdata, t.addr);
                check("vec_stall_ack", 32'(bus.stall), 32'd0);
                if (t.is_d) begin
                    model_d_rdata = exp_rd;
                end else begin
                    model_i_rdata = exp_rd;
                end
            end else begin
                sb_q.delete();
            end
            bus.i_req = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
            @(negedge CLK);
            check("vec_ack_i_once", 32'(bus.i_ack), 32'd0);
            check("vec_ack_d_once", 32'(bus.d_ack), 32'd0);
        end

        // Spurious mem_ack while idle with no requests.
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("spur_mem_req", 32'(bus.mem_req), 32'd0);
            check("spur_i_ack",   32'(bus.i_ack), 32'd0);
            check("spur_d_ack",   32'(bus.d_ack), 32'd0);
            check("spur_i_rdata", bus.i_rdata, model_i_rdata);
            check("spur_d_rdata", bus.d_rdata, model_d_rdata);
        end
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        @(negedge CLK);

        // Contention: fetch waits while loads stream; expect D,D,D,D,I twice.
        order      = 10'b01_1110_1111;
        cur_i_addr = 32'h0000_0080;
        bus.i_req  = 1'b1; bus.i_addr = cur_i_addr;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_0400;
        for (int g = 0; g < 10; g++) begin
            sb_q.push_back('{order[g], 32'h0000_1000 + 32'(g)});
            wait_grant(ok);
            if (!ok) begin
                sb_q.delete();
                break;
            end
            check("cont_owner_addr", bus.mem_addr, order[g] ? 32'h0000_0400 : cur_i_addr);
            check("cont_stall", 32'(bus.stall), 32'd1);
            finish_access(1, 32'h0000_1000 + 32'(g), bus.mem_addr);
            if (g == 4) begin
                cur_i_addr = 32'h0000_0084;
                bus.i_addr = cur_i_addr;
            end else if (g == 9) begin
                bus.i_req  = 1'b0;
                bus.d_read = 1'b0;
            end else begin
                bus.i_addr = cur_i_addr;
            end
        end
        bus.i_req = 1'b0; bus.d_read = 1'b0;
        model_d_rdata = 32'h0000_1008;
        model_i_rdata = 32'h0000_1009;
        repeat (2) @(negedge CLK);
        check("cont_i_rdata_hold", bus.i_rdata, model_i_rdata);
        check("cont_d_rdata_hold", bus.d_rdata, model_d_rdata);

        // Reset in the middle of a store, followed by a late mem_ack.
        bus.d_write = 1'b1; bus.d_addr = 32'h0000_0500; bus.d_wdata = 32'h0000_0011; bus.d_be = 4'hF;
        wait_grant(ok);
        if (ok) begin
            check("mid_mem_we", 32'(bus.mem_we), 32'd1);
        end
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        RST = 1'b0;
        bus.d_write = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0077;
        model_i_rdata = 32'h0;
        model_d_rdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            bus.mem_ack = 1'b0;
            check("mid_mem_req", 32'(bus.mem_req), 32'd0);
            check("mid_i_ack",   32'(bus.i_ack), 32'd0);
            check("mid_d_ack",   32'(bus.d_ack), 32'd0);
            check("mid_d_rdata", bus.d_rdata, model_d_rdata);
            check("mid_i_rdata", bus.i_rdata, model_i_rdata);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
